pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage pipelined CPU. It drives the enable and flush controls of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers. It resolves three conditions:
- load-use hazards, with a one-cycle bubble;
- taken branches resolved in EX, by flushing two stages;
- variable-latency data-memory accesses in MEM, by freezing the pipeline with a timeout.

It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_hazard_ctrl_if.sv | 47 ++++
 rtl/pipe_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundles the hazard-detection inputs, the data-memory handshake and the
// pipeline-register controls exchanged between the CPU datapath and the
// stall/flush sequencer.
//   master : datapath side, drives operand/hazard info and memory status,
//            receives enables, flushes, mem_start and debug status.
//   slave  : sequencer side (pipe_hazard_ctrl).
// Parameter CNT_W sets the width of the stall_count debug counter.
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ifid_rn;
    logic [4:0]       ifid_rm;
    logic             ifid_uses_rm;
    logic [4:0]       idex_rd;
    logic             idex_memread;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             mem_start;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             memwb_flush;
    logic             mem_error;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output ifid_rn, ifid_rm, ifid_uses_rm, idex_rd, idex_memread,
               branch_taken, mem_req, mem_ready,
        input  mem_start, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, memwb_flush, mem_error, stall_count
    );

    modport slave (
        input  ifid_rn, ifid_rm, ifid_uses_rm, idex_rd, idex_memread,
               branch_taken, mem_req, mem_ready,
        output mem_start, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, memwb_flush, mem_error, stall_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Stall/flush sequencer for the five-stage pipeline. Inserts a one-cycle
// bubble on load-use hazards, flushes IF_ID/ID_EX on taken branches and
// freezes the whole pipeline while a variable-latency data-memory access is
// outstanding, halting permanently (mem_error) after MEM_TIMEOUT wait cycles.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-low reset
//   bus  : pipe_hazard_ctrl_if.slave (hazard inputs, memory handshake,
//          register enables/flushes, mem_error, stall_count)
// Enables, flushes and mem_start are combinational (Mealy); mem_error and
// stall_count are registered.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);
    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [8:0] TIMEOUT_L = 9'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             mem_error_q, mem_error_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic load_use;
    logic freeze;
    logic mem_start;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, memwb_flush;

    // Next-state logic and FREEZE decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise a latch would be inferred.
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_error_d = mem_error_q;
        freeze      = 1'b0;
        mem_start   = 1'b0;

        case (state_q)
            ST_RUN: begin
                mem_start = bus.mem_req;
                if (bus.mem_req && !bus.mem_ready) begin
                    freeze     = 1'b1;
                    state_d    = ST_WAIT;
                    wait_cnt_d = 8'd0;
                end
            end
            ST_WAIT: begin
                // mem_ready is checked first so it wins the race against the
                // timeout in the same cycle.
                if (bus.mem_ready) begin
                    state_d = ST_RUN;
                end else begin
                    freeze     = 1'b1;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (({1'b0, wait_cnt_q} + 9'd1) == TIMEOUT_L) begin
                        state_d     = ST_HALT;
                        mem_error_d = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                freeze = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Pipeline register controls: reset > FREEZE > branch > load-use > run.
    always_comb begin
        load_use = bus.idex_memread && (bus.idex_rd != 5'd31) &&
                   ((bus.idex_rd == bus.ifid_rn) ||
                    (bus.ifid_uses_rm && (bus.idex_rd == bus.ifid_rm)));

        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;

        if (!rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
        end else if (freeze) begin
            // Upstream stages hold; writeback keeps draining bubbles.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (bus.branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            // ID_EX stays enabled so the bubble is actually loaded.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end

        stall_count_d = stall_count_q;
        if (!pc_en && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling the values
        // from before this edge, independent of statement order.
        if (!rst) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= 8'd0;
            mem_error_q   <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_error_q   <= mem_error_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.mem_start   = rst && mem_start;
    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.idex_en     = idex_en;
    assign bus.exmem_en    = exmem_en;
    assign bus.memwb_en    = memwb_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_flush  = idex_flush;
    assign bus.memwb_flush = memwb_flush;
    assign bus.mem_error   = mem_error_q;
    assign bus.stall_count = stall_count_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed vectors for pipe_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4). The driver
// applies one vector per cycle and pushes its hand-computed response into a
// queue; a monitor pops and compares on every falling edge.
// ctrl vector order: {pc,ifid,idex,exmem,memwb en, ifid,idex,memwb flush,
//                     mem_start}
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
    localparam logic [8:0] NORM  = 9'b11111_000_0;
    localparam logic [8:0] NORMS = 9'b11111_000_1;
    localparam logic [8:0] RST   = 9'b00000_111_0;
    localparam logic [8:0] FRZ   = 9'b00001_001_0;
    localparam logic [8:0] FRZS  = 9'b00001_001_1;
    localparam logic [8:0] BR    = 9'b11111_110_0;
    localparam logic [8:0] LU    = 9'b00111_010_0;

    typedef struct {
        int         idx;
        logic [8:0] ctrl;
        logic       err;
        logic [3:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(4)) bus ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   vec_idx = 0;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, req);
    endtask

    // One cycle of stimulus plus its expected response.
    task automatic vec(input logic rst_v, input logic [4:0] rn, input logic [4:0] rm,
                       input logic urm, input logic [4:0] rd, input logic mr,
                       input logic br, input logic mreq, input logic mrdy,
                       input logic [8:0] e_ctrl, input logic e_err, input logic [3:0] e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst              = rst_v;
        bus.ifid_rn      = rn;
        bus.ifid_rm      = rm;
        bus.ifid_uses_rm = urm;
        bus.idex_rd      = rd;
        bus.idex_memread = mr;
        bus.branch_taken = br;
        bus.mem_req      = mreq;
        bus.mem_ready    = mrdy;
        e.idx  = vec_idx;
        e.ctrl = e_ctrl;
        e.err  = e_err;
        e.cnt  = e_cnt;
        exp_q.push_back(e);
        vec_idx++;
    endtask

    // Monitor: the controller presents a response every cycle.
    initial begin
        exp_t e;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                       bus.ifid_flush, bus.idex_flush, bus.memwb_flush, bus.mem_start};
                check("ctrl", e.idx, 32'(act), 32'(e.ctrl));
                check("mem_error", e.idx, 32'(bus.mem_error), 32'(e.err));
                check("stall_count", e.idx, 32'(bus.stall_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        rst = 1'b0;
        bus.ifid_rn = 5'd1; bus.ifid_rm = 5'd2; bus.ifid_uses_rm = 1'b0;
        bus.idex_rd = 5'd0; bus.idex_memread = 1'b0; bus.branch_taken = 1'b0;
        bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        //   rst rn     rm     urm rd     mr br mreq rdy  ctrl  err cnt
        vec(0, 5'd1,  5'd2,  0, 5'd0,  0, 0, 0, 0, RST,  0, 4'd0);
        vec(1, 5'd1,  5'd2,  0, 5'd0,  0, 0, 0, 0, NORM, 0, 4'd0);
        // Load-use on Rn, then XZR never hazards.
        vec(1, 5'd3,  5'd2,  0, 5'd3,  1, 0, 0, 0, LU,   0, 4'd0);
        vec(1, 5'd1,  5'd2,  0, 5'd0,  0, 0, 0, 0, NORM, 0, 4'd1);
        vec(1, 5'd31, 5'd2,  0, 5'd31, 1, 0, 0, 0, NORM, 0, 4'd1);
        // Rm hazard only counts when Rm is used.
        vec(1, 5'd1,  5'd5,  0, 5'd5,  1, 0, 0, 0, NORM, 0, 4'd1);
        vec(1, 5'd1,  5'd5,  1, 5'd5,  1, 0, 0, 0, LU,   0, 4'd1);
        vec(1, 5'd1,  5'd2,  0, 5'd0,  0, 0, 0, 0, NORM, 0, 4'd2);
        // Register match but not a load.
        vec(1, 5'd3,  5'd2,  0, 5'd3,  0, 0, 0, 0, NORM, 0, 4'd2);
        // Branch overrides a load-use match; branch alone.
        vec(1, 5'd3,  5'd2,  0, 5'd3,  1, 1, 0, 0, BR,   0, 4'd2);
        vec(1, 5'd1,  5'd2,  0, 5'd0,  0, 1, 0, 0, BR,   0, 4'd2);
        vec(1, 5'd1,  5'd2,  0, 5'd0,  0, 0, 0, 0, NORM, 0, 4'd2);
        // Memory wait: 3 cycles not ready, hazards ignored while frozen,
        // load-use honoured in the release cycle.
        vec(1, 5'd1,  5'd2,  0, 5'd0,  0, 0, 1, 0, FRZS, 0, 4'd2);
        vec(1, 5'd3,  5'd2,  0, 5'd3,  1, 1, 1, 0, FRZ,  0, 4'd3);
        vec(1, 5'd1,  5'd2,  0, 5'd0,  0, 0, 1, 0, FRZ,  0, 4'd4);
        vec(1, 5'd3,  5'd2,  0, 5'd3,  1, 0, 1, 1, LU,   0, 4'd5);
        vec(1, 5'd1,  5'd2,  0, 5'd0,  0, 0, 0, 0, NORM, 0, 4'd6);
        // Zero-wait access.
        vec(1, 5'd1,  5'd2,  0, 5'd0,  0, 0, 1, 1, NORMS,0, 4'd6);
        vec(1, 5'd1,  5'd2,  0, 5'd0,  0, 0, 0, 0, NORM, 0, 4'd6);
        // Race: ready arrives on the 4th WAIT cycle.
        vec(1, 5'd1,  5'd2,  0, 5'd0,  0, 0, 1, 0, FRZS, 0, 4'd6);
        vec(1, 5'd1,  5'd2,  0, 5'd0,  0, 0, 1, 0, FRZ,  0, 4'd7);
        vec(1, 5'd1,  5'd2,  0, 5'd0,  0, 0, 1, 0, FRZ,  0, 4'd8);
        vec(1, 5'd1,  5'd2,  0, 5'd0,  0, 0, 1, 0, FRZ,  0, 4'd9);
        vec(1, 5'd1,  5'd2,  0, 5'd0,  0, 0, 1, 1, NORM, 0, 4'd10);
        vec(1, 5'd1,  5'd2,  0, 5'd0,  0, 0, 0, 0, NORM, 0, 4'd10);
        // Timeout: HALT after the 4th WAIT cycle without ready.
        vec(1, 5'd1,  5'd2,  0, 5'd0,  0, 0, 1, 0, FRZS, 0, 4'd10);
        vec(1, 5'd1,  5'd2,  0, 5'd0,  0, 0, 1, 0, FRZ,  0, 4'd11);
        vec(1, 5'd1,  5'd2,  0, 5'd0,  0, 0, 1, 0, FRZ,  0, 4'd12);
        vec(1, 5'd1,  5'd2,  0, 5'd0,  0, 0, 1, 0, FRZ,  0, 4'd13);
        vec(1, 5'd1,  5'd2,  0, 5'd0,  0, 0, 1, 0, FRZ,  0, 4'd14);
        // HALT ignores ready, branch and hazards; counter saturates at 15.
        vec(1, 5'd1,  5'd2,  0, 5'd0,  0, 0, 0, 1, FRZ,  1, 4'd15);
        for (int i = 0; i < 14; i++)
            vec(1, 5'd3, 5'd2, 0, 5'd3, 1, 1, 1, 0, FRZ, 1, 4'd15);
        // Reset from HALT.
        vec(0, 5'd1,  5'd2,  0, 5'd0,  0, 0, 0, 0, RST,  1, 4'd15);
        vec(1, 5'd1,  5'd2,  0, 5'd0,  0, 0, 0, 0, NORM, 0, 4'd0);
        vec(1, 5'd3,  5'd2,  0, 5'd3,  1, 0, 0, 0, LU,   0, 4'd0);
        // Reset mid-WAIT returns to RUN.
        vec(1, 5'd1,  5'd2,  0, 5'd0,  0, 0, 1, 0, FRZS, 0, 4'd1);
        vec(0, 5'd1,  5'd2,  0, 5'd0,  0, 0, 1, 0, RST,  0, 4'd2);
        vec(1, 5'd1,  5'd2,  0, 5'd0,  0, 0, 0, 0, NORM, 0, 4'd0);
        vec(1, 5'd1,  5'd2,  0, 5'd0,  0, 0, 0, 0, NORM, 0, 4'd0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
